// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer arbiter.
package fb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      WRITE = 2'd2
   } fb_state_t;

   localparam int unsigned DEF_RD_LAT = 2;

   // Width of a burst-length field able to hold 0..max_burst.
   function automatic int unsigned len_w(input int unsigned max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return tracker: RD_LAT-deep valid delay line with asynchronous clear.
// Memory data already lands on the last valid stage, so data is only gated.
module fb_rd_pipe #(
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              rd_issue,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              s_rvalid,
   output logic [DATA_W-1:0] s_rdata
);

   logic [RD_LAT-1:0] vld;

   generate
      if (RD_LAT == 1) begin : g_one
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) vld <= '0;
            else     vld <= rd_issue;
         end
      end else begin : g_deep
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) vld <= '0;
            else     vld <= {vld[RD_LAT-2:0], rd_issue};
         end
      end
   endgenerate

   assign s_rvalid = vld[RD_LAT-1];
   assign s_rdata  = vld[RD_LAT-1] ? m_rdata : '0;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout bursts over single-word writes.
// Define FB_ARB_STARVE_EN to bound writer starvation to STARVE_LIMIT grants.
module fb_arbiter
   import fb_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 20,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned MAX_BURST    = 64,
   parameter int unsigned RD_LAT       = DEF_RD_LAT,
`ifdef FB_ARB_STARVE_EN
   parameter int unsigned STARVE_LIMIT = 4,
`endif
   localparam int unsigned LEN_W       = len_w(MAX_BURST)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              s_req,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [LEN_W-1:0]  s_len,
   output logic              s_ack,
   output logic [DATA_W-1:0] s_rdata,
   output logic              s_rvalid,
   input  logic              w_req,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_wdata,
   output logic              w_ack,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy
);

   fb_state_t        state;
   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] len_c;
   logic             dec;
   logic             s_elig;
   logic             w_elig;
   logic             grant_s;
   logic             grant_w;
   logic             starved;
   logic             rd_issue;

`ifdef FB_ARB_STARVE_EN
   localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
   logic [STV_W-1:0] stv_cnt;

   assign starved = (stv_cnt == STV_W'(STARVE_LIMIT));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                           stv_cnt <= '0;
      else if (dec && grant_w)           stv_cnt <= '0;
      else if (dec && grant_s && w_elig) stv_cnt <= stv_cnt + 1'b1;
   end
`else
   assign starved = 1'b0;
`endif

   // A requester whose ack is high this cycle is excluded from the decision.
   always_comb begin
      len_c   = (s_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : s_len;
      dec     = (state == IDLE) || (state == WRITE) || ((state == SCAN) && (rem == '0));
      s_elig  = s_req & ~s_ack;
      w_elig  = w_req & ~w_ack;
      grant_w = w_elig & (~s_elig | starved);
      grant_s = s_elig & ~grant_w;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         rem     <= '0;
         s_ack   <= 1'b0;
         w_ack   <= 1'b0;
         m_en    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         busy    <= 1'b0;
      end else begin
         s_ack <= 1'b0;
         w_ack <= 1'b0;
         m_en  <= 1'b0;
         if (!dec) begin
            m_en   <= 1'b1;
            m_addr <= m_addr + 1'b1;
            rem    <= rem - 1'b1;
         end else if (grant_w) begin
            state   <= WRITE;
            busy    <= 1'b1;
            m_en    <= 1'b1;
            m_we    <= 1'b1;
            m_addr  <= w_addr;
            m_wdata <= w_wdata;
            w_ack   <= 1'b1;
         end else if (grant_s) begin
            s_ack <= 1'b1;
            if (len_c == '0) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               state  <= SCAN;
               busy   <= 1'b1;
               m_en   <= 1'b1;
               m_we   <= 1'b0;
               m_addr <= s_addr;
               rem    <= len_c - 1'b1;
            end
         end else begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end

   assign rd_issue = m_en & ~m_we;

   fb_rd_pipe #(
      .RD_LAT (RD_LAT),
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .CLK      (CLK),
      .RST      (RST),
      .rd_issue (rd_issue),
      .m_rdata  (m_rdata),
      .s_rvalid (s_rvalid),
      .s_rdata  (s_rdata)
   );

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter against a cycle-schedule reference model.
// The FB_ARB_STARVE_EN macro selects the matching writer-starvation expectations.
module tb_fb_arbiter;

   localparam int unsigned ADDR_W    = 20;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned MAX_BURST = 64;
   localparam int unsigned RD_LAT    = 2;
`ifdef FB_ARB_STARVE_EN
   localparam int unsigned STV_LIMIT = 4;
`endif
   localparam int N = 8192;

   logic              CLK = 1'b0;
   logic              RST;
   logic              s_req;
   logic [ADDR_W-1:0] s_addr;
   logic [6:0]        s_len;
   logic              s_ack;
   logic [DATA_W-1:0] s_rdata;
   logic              s_rvalid;
   logic              w_req;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_ack;
   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_on = 1'b0;

   // Expected behaviour per cycle, filled in from the request rules.
   bit              exp_en   [N];
   bit              exp_we   [N];
   bit              exp_sack [N];
   bit              exp_wack [N];
   bit              exp_busy [N];
   bit              exp_rv   [N];
   bit [ADDR_W-1:0] exp_addr [N];
   bit [DATA_W-1:0] exp_wd   [N];
   bit [DATA_W-1:0] exp_rd   [N];

   fb_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST),
      .RD_LAT    (RD_LAT)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .s_req    (s_req),
      .s_addr   (s_addr),
      .s_len    (s_len),
      .s_ack    (s_ack),
      .s_rdata  (s_rdata),
      .s_rvalid (s_rvalid),
      .w_req    (w_req),
      .w_addr   (w_addr),
      .w_wdata  (w_wdata),
      .w_ack    (w_ack),
      .m_en     (m_en),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .busy     (busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [DATA_W-1:0] fdata(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ {a[19:16], 12'h5A3};
   endfunction

   // Memory: data for the address of cycle c is presented in cycle c+RD_LAT.
   logic [ADDR_W-1:0] rd_a [RD_LAT];
   always @(posedge CLK) begin
      rd_a[0] <= m_addr;
      for (int i = 1; i < RD_LAT; i++) rd_a[i] <= rd_a[i-1];
   end
   assign m_rdata = fdata(rd_a[RD_LAT-1]);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (mon_on) begin
         check("s_ack", 32'(s_ack), 32'(exp_sack[cyc]));
         check("w_ack", 32'(w_ack), 32'(exp_wack[cyc]));
         check("m_en", 32'(m_en), 32'(exp_en[cyc]));
         check("busy", 32'(busy), 32'(exp_busy[cyc]));
         check("s_rvalid", 32'(s_rvalid), 32'(exp_rv[cyc]));
         if (exp_en[cyc]) begin
            check("m_we", 32'(m_we), 32'(exp_we[cyc]));
            check("m_addr", 32'(m_addr), 32'(exp_addr[cyc]));
            if (exp_we[cyc]) check("m_wdata", 32'(m_wdata), 32'(exp_wd[cyc]));
         end
         if (exp_rv[cyc]) check("s_rdata", 32'(s_rdata), 32'(exp_rd[cyc]));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".s_ack"}, 32'(s_ack), 0);
      check({tag, ".w_ack"}, 32'(w_ack), 0);
      check({tag, ".m_en"}, 32'(m_en), 0);
      check({tag, ".m_we"}, 32'(m_we), 0);
      check({tag, ".s_rvalid"}, 32'(s_rvalid), 0);
      check({tag, ".busy"}, 32'(busy), 0);
      check({tag, ".m_addr"}, 32'(m_addr), 0);
      check({tag, ".m_wdata"}, 32'(m_wdata), 0);
      check({tag, ".s_rdata"}, 32'(s_rdata), 0);
   endtask

   task automatic sched_read(input int c, input logic [ADDR_W-1:0] a);
      exp_en[c]          = 1'b1;
      exp_we[c]          = 1'b0;
      exp_addr[c]        = a;
      exp_busy[c]        = 1'b1;
      exp_rv[c+RD_LAT]   = 1'b1;
      exp_rd[c+RD_LAT]   = fdata(a);
   endtask

   task automatic sched_write(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_en[c]   = 1'b1;
      exp_we[c]   = 1'b1;
      exp_addr[c] = a;
      exp_wd[c]   = d;
      exp_wack[c] = 1'b1;
      exp_busy[c] = 1'b1;
   endtask

   // Burst acked in cycle c; returns the cycle of its last read (c if empty).
   task automatic sched_burst(input int c, input logic [ADDR_W-1:0] a, input int len, output int e);
      int l;
      l = (len > int'(MAX_BURST)) ? int'(MAX_BURST) : len;
      exp_sack[c] = 1'b1;
      for (int i = 0; i < l; i++) sched_read(c + i, a + ADDR_W'(i));
      e = (l == 0) ? c : c + l - 1;
   endtask

   task automatic run_burst(input logic [ADDR_W-1:0] a, input int len);
      int t0, e;
      t0 = cyc;
      s_req = 1'b1; s_addr = a; s_len = 7'(len);
      sched_burst(t0 + 1, a, len, e);
      tick(); tick();
      s_req = 1'b0;
      while (cyc < e + int'(RD_LAT) + 2) tick();
   endtask

   task automatic run_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      w_req = 1'b1; w_addr = a; w_wdata = d;
      sched_write(cyc + 1, a, d);
      tick(); tick();
      w_req = 1'b0;
      tick(); tick();
   endtask

   task automatic run_contend(input logic [ADDR_W-1:0] a, input int len,
                              input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
      int t0, e, l, wc;
      t0 = cyc;
      l  = (len > int'(MAX_BURST)) ? int'(MAX_BURST) : len;
      s_req = 1'b1; s_addr = a; s_len = 7'(len);
      w_req = 1'b1; w_addr = wa; w_wdata = wd;
      sched_burst(t0 + 1, a, len, e);
      wc = t0 + ((l == 0) ? 1 : l) + 1;
      sched_write(wc, wa, wd);
      tick(); tick();
      s_req = 1'b0;
      while (cyc < wc + 1) tick();
      w_req = 1'b0;
      while (cyc < wc + int'(RD_LAT) + 3) tick();
   endtask

   // Scanout requester re-arms immediately after each ack; optional waiting writer.
   task automatic run_b2b(input int nb, input bit with_w);
      logic [ADDR_W-1:0] ba [8];
      int                bl [8];
      int                ack[8];
      int                t0, c, e, wc;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
`ifdef FB_ARB_STARVE_EN
      int                cnt;
      cnt = 0;
`endif
      for (int k = 0; k < nb; k++) begin
         ba[k] = ADDR_W'($urandom);
         bl[k] = int'($urandom_range(2, 16));
      end
      wa = ADDR_W'($urandom);
      wd = DATA_W'($urandom);
      t0 = cyc; c = t0 + 1; wc = -1;
      for (int k = 0; k < nb; k++) begin
         ack[k] = c;
         sched_burst(c, ba[k], bl[k], e);
         c = e + 1;
`ifdef FB_ARB_STARVE_EN
         if (with_w && wc < 0) begin
            cnt++;
            if (cnt == int'(STV_LIMIT) && k < nb - 1) begin
               wc = c;
               sched_write(c, wa, wd);
               c++;
            end
         end
`endif
      end
      if (with_w && wc < 0) begin
         wc = c;
         sched_write(c, wa, wd);
         c++;
      end
      s_req = 1'b1; s_addr = ba[0]; s_len = 7'(bl[0]);
      if (with_w) begin
         w_req = 1'b1; w_addr = wa; w_wdata = wd;
      end
      while (cyc < c + int'(RD_LAT) + 2) begin
         tick();
         for (int k = 0; k < nb; k++) begin
            if (cyc == ack[k] + 1) begin
               if (k < nb - 1) begin
                  s_addr = ba[k+1];
                  s_len  = 7'(bl[k+1]);
               end else begin
                  s_req = 1'b0;
               end
            end
         end
         if (with_w && cyc == wc + 1) w_req = 1'b0;
      end
   endtask

   task automatic run_reset_mid();
      int t0, e;
      t0 = cyc;
      s_req = 1'b1; s_addr = ADDR_W'($urandom); s_len = 7'd8;
      sched_burst(t0 + 1, s_addr, 8, e);
      tick(); tick();
      s_req = 1'b0;
      tick();
      #2;
      RST    = 1'b1;
      mon_on = 1'b0;
      for (int c = t0 + 3; c < t0 + 64; c++) begin
         exp_en[c] = 1'b0; exp_we[c] = 1'b0; exp_sack[c] = 1'b0; exp_wack[c] = 1'b0;
         exp_busy[c] = 1'b0; exp_rv[c] = 1'b0; exp_addr[c] = '0;
      end
      #1;
      check_zero("rst_mid");
      @(negedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK);
      #1 mon_on = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      RST = 1'b1;
      s_req = 1'b0; s_addr = '0; s_len = '0;
      w_req = 1'b0; w_addr = '0; w_wdata = '0;
      repeat (3) @(posedge CLK);
      #1 check_zero("reset");
      @(negedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK);
      #1 mon_on = 1'b1;
      tick();

      run_burst(20'h00100, 4);
      run_burst(20'hFFFFE, 4);
      run_burst(20'h12345, 0);
      run_burst(20'h00200, 100);
      run_burst(20'hABCDE, 1);
      for (int i = 0; i < 8; i++) run_burst(ADDR_W'($urandom), int'($urandom_range(0, 100)));

      for (int i = 0; i < 6; i++) run_write(ADDR_W'($urandom), DATA_W'($urandom));

      run_contend(20'h00300, 8, 20'h0BEEF, 16'hCAFE);
      run_contend(ADDR_W'($urandom), 0, ADDR_W'($urandom), DATA_W'($urandom));
      run_contend(ADDR_W'($urandom), 1, ADDR_W'($urandom), DATA_W'($urandom));
      for (int i = 0; i < 3; i++)
         run_contend(ADDR_W'($urandom), int'($urandom_range(0, 70)),
                     ADDR_W'($urandom), DATA_W'($urandom));

      run_b2b(5, 1'b0);
      run_b2b(6, 1'b1);

      run_reset_mid();
      run_burst(20'h00400, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
